// File: rtl/instr_fetch_unit.sv
// Instruction fetch datapath: program counter, two-byte instruction register
// assembly driven by the controller strobes, and the memory address mux.
module instr_fetch_unit #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 13,  // must equal 2*DW-3 (3 opcode bits on top)
  parameter int unsigned PC_RESET = 0
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic [DW-1:0] data,
  input  logic          rd,
  input  logic          load_ir,
  input  logic          inc_pc,
  input  logic          load_pc,
  input  logic          halt,
  input  logic          fetch,
  output logic [2:0]    opcode,
  output logic [AW-1:0] ir_addr,
  output logic [AW-1:0] pc_addr,
  output logic [AW-1:0] addr,
  output logic          ir_valid,
  output logic          halted,
  output logic          seq_err
);

  // Byte pointer: which IR byte the next capture writes
  typedef enum logic [1:0] {S_HI, S_LO, S_DONE} ptr_e;

  ptr_e              state_q, state_d;
  logic [2*DW-1:0]   ir_q, ir_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              halted_q, halted_d;
  logic              seq_err_q, seq_err_d;

  logic              cap;
  logic              ld_hi, ld_lo, err_set;

  // A capture needs both strobes; once halted nothing is captured
  assign cap = load_ir & rd & ~halted_q;

  // Byte-pointer state register
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state_q <= S_HI;
    else     state_q <= state_d;
  end

  // Byte-pointer next state; load_ir without rd parks the pointer in place
  always_comb begin
    state_d = state_q;
    if (halted_q || !load_ir) begin
      state_d = S_HI;
    end else if (cap) begin
      case (state_q)
        S_HI:    state_d = S_LO;
        S_LO:    state_d = S_DONE;
        default: state_d = S_DONE;
      endcase
    end
  end

  // Byte-pointer outputs: which byte loads, and protocol violations
  // (third consecutive capture, or the pair broken after the high byte;
  // the forced return to HI while halted is not a violation)
  always_comb begin
    ld_hi   = cap && (state_q == S_HI);
    ld_lo   = cap && (state_q == S_LO);
    err_set = (cap && (state_q == S_DONE)) ||
              (!halted_q && !load_ir && (state_q == S_LO));
  end

  // Datapath next state: IR bytes, valid flag, PC priority, sticky flags
  always_comb begin
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    if (ld_hi) begin
      ir_d[2*DW-1:DW] = data;
      ir_valid_d      = 1'b0;
    end
    if (ld_lo) begin
      ir_d[DW-1:0] = data;
      ir_valid_d   = 1'b1;
    end

    pc_d = pc_q;
    if (!halted_q) begin
      if (load_pc)     pc_d = ir_q[AW-1:0];  // JMP raises both; jump wins
      else if (inc_pc) pc_d = pc_q + 1'b1;   // wraps modulo 2^AW
    end

    halted_d  = halted_q | halt;
    seq_err_d = seq_err_q | err_set;
  end

  // Datapath registers
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      ir_q       <= '0;
      pc_q       <= AW'(PC_RESET);
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign opcode   = ir_q[2*DW-1 -: 3];
  assign ir_addr  = ir_q[AW-1:0];
  assign pc_addr  = pc_q;
  assign addr     = fetch ? pc_q : ir_q[AW-1:0];
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed per-cycle vectors push
// hand-computed expectations; a monitor pops and compares after each posedge.
module tb_instr_fetch_unit;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  logic [7:0]  data = '0;
  logic        rd = 0, load_ir = 0, inc_pc = 0, load_pc = 0, halt = 0, fetch = 0;
  logic [2:0]  opcode;
  logic [12:0] ir_addr, pc_addr, addr;
  logic        ir_valid, halted, seq_err;

  instr_fetch_unit dut (
    .clk1(clk1), .rst(rst), .data(data), .rd(rd), .load_ir(load_ir),
    .inc_pc(inc_pc), .load_pc(load_pc), .halt(halt), .fetch(fetch),
    .opcode(opcode), .ir_addr(ir_addr), .pc_addr(pc_addr), .addr(addr),
    .ir_valid(ir_valid), .halted(halted), .seq_err(seq_err)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    string       nm;
    logic [15:0] ir;
    logic [12:0] pc;
    logic        f, iv, hl, se;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, req);
  endtask

  // Monitor: one expectation per clock, checked just after the edge
  initial begin
    forever begin
      @(posedge clk1);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk(e.nm, "opcode",   16'(opcode),   16'(e.ir[15:13]));
        chk(e.nm, "ir_addr",  16'(ir_addr),  16'(e.ir[12:0]));
        chk(e.nm, "pc_addr",  16'(pc_addr),  16'(e.pc));
        chk(e.nm, "addr",     16'(addr),     16'(e.f ? e.pc : e.ir[12:0]));
        chk(e.nm, "ir_valid", 16'(ir_valid), 16'(e.iv));
        chk(e.nm, "halted",   16'(halted),   16'(e.hl));
        chk(e.nm, "seq_err",  16'(seq_err),  16'(e.se));
      end
    end
  end

  // One controller cycle: drive on negedge, optional async rst pulse that is
  // released before the posedge, then queue what the posedge must produce.
  task automatic cyc(input string nm, input logic [7:0] d,
                     input logic r, li, inc, lpc, h, f, rp,
                     input logic [15:0] eir, input logic [12:0] epc,
                     input logic eiv, ehl, ese);
    exp_t e;
    @(negedge clk1);
    data = d; rd = r; load_ir = li; inc_pc = inc; load_pc = lpc; halt = h; fetch = f;
    if (rp) begin
      #1 rst = 1'b1;
      #1 rst = 1'b0;
    end
    e.nm = nm; e.ir = eir; e.pc = epc; e.f = f; e.iv = eiv; e.hl = ehl; e.se = ese;
    q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk1);
    @(negedge clk1) rst = 1'b0;

    //   name     data  rd li inc lpc h  f  rp  ir        pc        iv hl se
    cyc("rst0",   8'h00, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 13'h0000, 0, 0, 0);
    // two-byte fetch
    cyc("f_hi",   8'hA0, 1, 1, 0, 0, 0, 1, 0, 16'hA000, 13'h0000, 0, 0, 0);
    cyc("f_lo",   8'h0C, 1, 1, 1, 0, 0, 1, 0, 16'hA00C, 13'h0001, 1, 0, 0);
    cyc("f_opnd", 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'hA00C, 13'h0001, 1, 0, 0);
    // JMP: load_pc beats inc_pc
    cyc("j_hi",   8'hE1, 1, 1, 0, 0, 0, 1, 0, 16'hE10C, 13'h0001, 0, 0, 0);
    cyc("j_lo",   8'h23, 1, 1, 1, 0, 0, 1, 0, 16'hE123, 13'h0002, 1, 0, 0);
    cyc("jmp",    8'h00, 0, 0, 1, 1, 0, 1, 0, 16'hE123, 13'h0123, 1, 0, 0);
    // async reset from pc=0x0123, IR=0xFFFF
    cyc("ff_hi",  8'hFF, 1, 1, 0, 0, 0, 1, 0, 16'hFF23, 13'h0123, 0, 0, 0);
    cyc("ff_lo",  8'hFF, 1, 1, 0, 0, 0, 1, 0, 16'hFFFF, 13'h0123, 1, 0, 0);
    cyc("ff_idl", 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF, 13'h0123, 1, 0, 0);
    cyc("rst1",   8'h00, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 13'h0000, 0, 0, 0);
    // PC wrap
    cyc("w_hi",   8'h1F, 1, 1, 0, 0, 0, 1, 0, 16'h1F00, 13'h0000, 0, 0, 0);
    cyc("w_lo",   8'hFF, 1, 1, 0, 0, 0, 1, 0, 16'h1FFF, 13'h0000, 1, 0, 0);
    cyc("w_ld",   8'h00, 0, 0, 0, 1, 0, 1, 0, 16'h1FFF, 13'h1FFF, 1, 0, 0);
    cyc("w_inc",  8'h00, 0, 0, 1, 0, 0, 1, 0, 16'h1FFF, 13'h0000, 1, 0, 0);
    // three consecutive captures
    cyc("t_hi",   8'h12, 1, 1, 0, 0, 0, 1, 0, 16'h12FF, 13'h0000, 0, 0, 0);
    cyc("t_lo",   8'h34, 1, 1, 0, 0, 0, 1, 0, 16'h1234, 13'h0000, 1, 0, 0);
    cyc("t_3rd",  8'h56, 1, 1, 0, 0, 0, 1, 0, 16'h1234, 13'h0000, 1, 0, 1);
    cyc("t_stk",  8'h00, 0, 0, 0, 0, 0, 1, 0, 16'h1234, 13'h0000, 1, 0, 1);
    cyc("rst2",   8'h00, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 13'h0000, 0, 0, 0);
    // load_ir without rd: no capture, pointer holds
    cyc("n_hi",   8'hAB, 1, 1, 0, 0, 0, 1, 0, 16'hAB00, 13'h0000, 0, 0, 0);
    cyc("n_nord", 8'hCD, 0, 1, 0, 0, 0, 1, 0, 16'hAB00, 13'h0000, 0, 0, 0);
    cyc("n_lo",   8'hCD, 1, 1, 0, 0, 0, 1, 0, 16'hABCD, 13'h0000, 1, 0, 0);
    cyc("n_idl",  8'h00, 0, 0, 0, 0, 0, 1, 0, 16'hABCD, 13'h0000, 1, 0, 0);
    // broken pair after the high byte
    cyc("b_hi",   8'h77, 1, 1, 0, 0, 0, 1, 0, 16'h77CD, 13'h0000, 0, 0, 0);
    cyc("b_brk",  8'h00, 0, 0, 0, 0, 0, 1, 0, 16'h77CD, 13'h0000, 0, 0, 1);
    cyc("rst3",   8'h00, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 13'h0000, 0, 0, 0);
    // reset between the two bytes
    cyc("m_hi",   8'h99, 1, 1, 0, 0, 0, 1, 0, 16'h9900, 13'h0000, 0, 0, 0);
    cyc("m_rst",  8'h00, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 13'h0000, 0, 0, 0);
    cyc("m_hi2",  8'h42, 1, 1, 0, 0, 0, 1, 0, 16'h4200, 13'h0000, 0, 0, 0);
    cyc("m_lo2",  8'h33, 1, 1, 0, 0, 0, 1, 0, 16'h4233, 13'h0000, 1, 0, 0);
    cyc("m_idl",  8'h00, 0, 0, 0, 0, 0, 1, 0, 16'h4233, 13'h0000, 1, 0, 0);
    // halt at pc=5 with inc_pc, then everything frozen
    cyc("h_hi",   8'h00, 1, 1, 0, 0, 0, 1, 0, 16'h0033, 13'h0000, 0, 0, 0);
    cyc("h_lo",   8'h05, 1, 1, 0, 0, 0, 1, 0, 16'h0005, 13'h0000, 1, 0, 0);
    cyc("h_ld5",  8'h00, 0, 0, 0, 1, 0, 1, 0, 16'h0005, 13'h0005, 1, 0, 0);
    cyc("h_halt", 8'h00, 0, 0, 1, 0, 1, 1, 0, 16'h0005, 13'h0006, 1, 1, 0);
    cyc("h_frz1", 8'h55, 1, 1, 1, 1, 0, 1, 0, 16'h0005, 13'h0006, 1, 1, 0);
    cyc("h_frz2", 8'h55, 1, 1, 0, 0, 0, 0, 0, 16'h0005, 13'h0006, 1, 1, 0);
    cyc("h_frz3", 8'h00, 0, 0, 1, 0, 0, 1, 0, 16'h0005, 13'h0006, 1, 1, 0);

    @(negedge clk1);
    data = '0; rd = 0; load_ir = 0; inc_pc = 0; load_pc = 0; halt = 0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk1);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Datapath stage directly downstream of the CPU control state machine. Consumes its inc_pc, load_pc, rd, load_ir and halt strobes.
- Holds the program counter and assembles the 16-bit instruction register from two byte-wide bus reads.
- Returns opcode to the controller and drives the memory address mux (PC during fetch, IR operand address otherwise).

Parameters:
- DW, 8, data bus width; instruction register is 2*DW bits.
- AW, 13, address width; must equal 2*DW-3.
- PC_RESET, 0, program counter value after reset.

Ports:
- clk1  in  1  system clock; all state updates on posedge (controller updates on negedge).
- rst  in  1  asynchronous, active-high reset.
- data  in  DW  memory/data bus read value.
- rd  in  1  controller read strobe.
- load_ir  in  1  controller instruction-register load strobe.
- inc_pc  in  1  controller PC increment strobe.
- load_pc  in  1  controller PC load strobe (jump).
- halt  in  1  controller halt strobe.
- fetch  in  1  address-mux select: 1 = PC, 0 = IR operand address.
- opcode  out  3  IR[2*DW-1 -: 3], to controller.
- ir_addr  out  AW  IR[AW-1:0], operand/jump address.
- pc_addr  out  AW  current PC.
- addr  out  AW  fetch ? pc_addr : ir_addr (combinational).
- ir_valid  out  1  both IR bytes of the current instruction captured.
- halted  out  1  sticky halt status.
- seq_err  out  1  sticky fetch-protocol error.

Behaviour:
- Reset (async, rst=1): pc=PC_RESET, IR=0 (opcode=0, ir_addr=0), byte pointer=HI, ir_valid=0, halted=0, seq_err=0. addr follows fetch from these values.
- Capture condition: cap = load_ir & rd & ~halted. load_ir without rd captures nothing and leaves the pointer unchanged.
- Byte-pointer FSM, states HI, LO, DONE:
  - HI + cap: IR[2*DW-1:DW] <= data; ir_valid <= 0; go to LO.
  - LO + cap: IR[DW-1:0] <= data; ir_valid <= 1; go to DONE.
  - DONE + cap (third consecutive capture): data ignored; seq_err <= 1; stay DONE.
  - Any state with load_ir=0: go to HI on the next edge. IR and ir_valid hold.
  - LO with load_ir=0 (sequence broken after the high byte): seq_err <= 1; ir_valid stays 0.
- Latency: opcode valid 1 posedge after the HI capture. ir_addr complete and ir_valid=1 1 posedge after the LO capture.
- PC update, in priority order:
  - halted=1: PC frozen.
  - load_pc=1: pc <= ir_addr. load_pc wins over inc_pc when both are high (JMP cycle asserts both).
  - inc_pc=1: pc <= pc+1 modulo 2^AW (0x1FFF -> 0x0000 at default AW).
  - Otherwise: hold.
- Halt: halted <= 1 on a posedge with halt=1.
  - The inc_pc in that same cycle is still applied, so PC points past HLT.
  - From the next edge, PC and IR are frozen, cap is suppressed, and the FSM is forced to HI.
  - Only rst clears halted.
- Reset mid-fetch: async; the partially assembled IR is discarded (all fields zero). Pointer=HI. The first cap after rst release loads the high byte.
- seq_err is sticky until rst and does not block operation.

Test Plan:
- Reset: rst pulse while pc=0x0123, IR=0xFFFF -> immediately pc_addr=0, opcode=0, ir_valid=0, halted=0, seq_err=0.
- Two-byte fetch: load_ir&rd for 2 cycles with data 0xA0 then 0x0C, inc_pc on 2nd cycle -> opcode=3'b101, ir_addr=0x000C, ir_valid=1, pc=1. addr=0x0001 with fetch=1, 0x000C with fetch=0.
- JMP: IR=0xE123, inc_pc=1 and load_pc=1 same cycle -> pc=0x0123 (not ir_addr+1).
- Wrap: pc=0x1FFF, inc_pc pulse -> pc=0x0000.
- Halt: halt=1 with inc_pc=1 at pc=5 -> pc=6, halted=1. Then inc_pc, load_pc and load_ir&rd with data=0x55 -> pc stays 6, IR unchanged.
- Protocol errors:
  - Three consecutive load_ir&rd cycles -> seq_err=1, IR keeps first two bytes.
  - Separately: high-byte capture followed by a load_ir=0 cycle -> seq_err=1, ir_valid=0.
  - Assert rst between the two bytes -> IR=0, next capture goes to the high byte.
